seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the match counter.
REQ-003 SHALL have derived constant LEN_W = clog2(MAX_LEN+1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_pattern  input  MAX_LEN  target pattern; bit [cfg_len-1] is the first bit received and bit [0] the last.
REQ-008 SHALL have port cfg_len  input  LEN_W  pattern length.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port in_valid  input  1  serial input bit qualifier.
REQ-011 SHALL have port in  input  1  serial input bit.
REQ-012 SHALL have port det  output  1  Mealy match flag, combinational, asserted in the cycle the final pattern bit is presented.
REQ-013 SHALL have port armed  output  1  registered, high when a valid configuration is loaded.
REQ-014 SHALL have port cfg_err  output  1  registered one-cycle pulse flagging an illegal cfg_len.
REQ-015 SHALL have port match_cnt  output  CNT_W  registered count of matches.

Function
REQ-016 SHALL implement a two-state control FSM, UNCFG and ARMED, plus a MAX_LEN-bit history register (hist), a fill counter (fill, 0..MAX_LEN) and latched copies of pattern, length and overlap mode.
REQ-017 cfg_we with 2 <= cfg_len <= MAX_LEN SHALL latch the configuration, clear hist, fill and match_cnt, and enter ARMED on the next edge, from either state.
REQ-018 cfg_we with an illegal cfg_len (<2 or >MAX_LEN) SHALL enter UNCFG, pulse cfg_err for one cycle and clear fill and match_cnt.
REQ-019 In UNCFG, input bits SHALL be ignored and det SHALL be 0.
REQ-020 In ARMED, with in_valid=1, det SHALL equal 1 iff fill+1 >= len and the low len bits of {hist,in} equal the low len bits of the latched pattern.
REQ-021 det SHALL be 0 whenever in_valid=0; cycles with in_valid=0 SHALL leave all state unchanged.
REQ-022 Each accepted bit SHALL shift hist left with in entering at bit 0, and set fill to min(fill+1, MAX_LEN).
REQ-023 On a match with overlap=0, fill SHALL instead be set to 0, so that no bit of a detected pattern is reused.
REQ-024 On a match with overlap=1, fill SHALL update normally, so that suffix bits may start the next match.
REQ-025 When cfg_we and in_valid are high in the same cycle, cfg_we SHALL win: the bit is discarded and det=0.
REQ-026 On each det=1 cycle, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1.

Reset
REQ-027 rst=1 at a clock edge SHALL force UNCFG, hist=0, fill=0, armed=0, cfg_err=0, match_cnt=0 and a latched length of 0; det SHALL be 0 while in UNCFG.
REQ-028 rst SHALL take priority over cfg_we and in_valid, including mid-pattern, and any partial match SHALL be lost.

Configuration
REQ-029 With macro SEQ_DET_CNT_EN defined, the match counter SHALL be implemented per REQ-026.
REQ-030 Without SEQ_DET_CNT_EN, match_cnt SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package seq_det_pkg SHALL hold the FSM state typedef (UNCFG, ARMED), constant MIN_LEN=2 and the LEN_W sizing function.
REQ-032 The masked compare of {hist,in} against the pattern, including the length mask and the fill check, SHALL be a combinational sub-module seq_det_match.

Verification
REQ-033 len=5, pattern=5'b11010, overlap=1, stream 0,1,1,0,1,0,0,1,0,1,1,0,1,0,1 with valid every cycle -> det=1 only on the 6th and 14th bits; match_cnt=2.
REQ-034 len=4, pattern=4'b1011, stream 1011011: overlap=1 -> det on the 4th and 7th bits; overlap=0 -> det on the 4th bit only.
REQ-035 len=3, pattern=3'b101, bits 1,0,1 separated by 2-cycle in_valid=0 gaps -> det=1 only in the cycle of the final valid 1.
REQ-036 cfg_len=1, then cfg_len=MAX_LEN+1 -> each gives a cfg_err pulse, armed=0, and det stays 0 on any stream.
REQ-037 rst asserted after 4 of 5 pattern bits, then the 5th bit presented -> no det; the full pattern is required after reconfiguration.
REQ-038 CNT_W=2, pattern=2'b11, overlap=1, five 1s -> match_cnt saturates at 3; a cfg_we in the same cycle as a valid bit discards the bit and clears match_cnt.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the parameterised serial sequence detector.
package seq_det_pkg;

   typedef enum logic {UNCFG, ARMED} detState_e;

   localparam int MIN_LEN = 2;

   // Width needed to hold a length value in the range 0..maxLen inclusive.
   function automatic int lenWidth(input int maxLen);
      return $clog2(maxLen + 1);
   endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial input and status bundle for seq_detector_param.
interface seq_detector_param_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
) ();
   import seq_det_pkg::*;

   localparam int LEN_W = lenWidth(MAX_LEN);

   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in;
   logic               det;
   logic               armed;
   logic               cfg_err;
   logic [CNT_W-1:0]   match_cnt;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
      input  det, armed, cfg_err, match_cnt
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in,
      output det, armed, cfg_err, match_cnt
   );

endinterface

// File: rtl/seq_det_match.sv
// Combinational masked compare of the shift history plus the incoming bit
// against the latched pattern, qualified by enough bits having been seen.
module seq_det_match
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8
) (
   input  logic [MAX_LEN-1:0]           hist,
   input  logic                         inBit,
   input  logic [MAX_LEN-1:0]           pattern,
   input  logic [lenWidth(MAX_LEN)-1:0] len,
   input  logic [lenWidth(MAX_LEN)-1:0] fill,
   output logic                         hit
);

   localparam int LEN_W = lenWidth(MAX_LEN);

   logic [MAX_LEN:0] window;
   logic [MAX_LEN:0] lenMask;
   logic [LEN_W:0]   fillPlus;

   // The window keeps one spare top bit; the mask never reaches it because len <= MAX_LEN.
   always_comb begin
      window   = {hist, inBit};
      lenMask  = '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
         lenMask[i] = (i < int'(len));
      end
      fillPlus = {1'b0, fill} + (LEN_W+1)'(1);
      hit      = (((window ^ {1'b0, pattern}) & lenMask) == '0)
                 && (fillPlus >= {1'b0, len});
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
) (
   input logic                  clk,
   input logic                  rst,
   seq_detector_param_if.slave  bus
);

   localparam int LEN_W = lenWidth(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

   detState_e          state_q;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic               armed_q;
   logic               cfgErr_q;
   logic               cfgLegal;
   logic               accept;
   logic               hit;
   logic               det;

   seq_det_match #(.MAX_LEN(MAX_LEN)) u_match (
      .hist    (hist_q),
      .inBit   (bus.in),
      .pattern (pat_q),
      .len     (len_q),
      .fill    (fill_q),
      .hit     (hit)
   );

   // A bit is only consumed when nothing with higher priority (reset, config) is happening.
   always_comb begin
      cfgLegal = (bus.cfg_len >= LEN_MIN) && (bus.cfg_len <= LEN_MAX);
      accept   = !rst && !bus.cfg_we && bus.in_valid && (state_q == ARMED);
      det      = accept && hit;
      hist_d   = {hist_q[MAX_LEN-2:0], bus.in};
      if (hit && !overlap_q)
         fill_d = '0;
      else if (fill_q == LEN_MAX)
         fill_d = fill_q;
      else
         fill_d = fill_q + LEN_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= UNCFG;
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         armed_q   <= 1'b0;
         cfgErr_q  <= 1'b0;
      end else begin
         cfgErr_q <= 1'b0;
         if (bus.cfg_we) begin
            fill_q <= '0;
            if (cfgLegal) begin
               state_q   <= ARMED;
               armed_q   <= 1'b1;
               hist_q    <= '0;
               pat_q     <= bus.cfg_pattern;
               len_q     <= bus.cfg_len;
               overlap_q <= bus.cfg_overlap;
            end else begin
               state_q  <= UNCFG;
               armed_q  <= 1'b0;
               cfgErr_q <= 1'b1;
            end
         end else if (accept) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
         end
      end
   end

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Any configuration write restarts the count, legal or not.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (bus.cfg_we)
         cnt_q <= '0;
      else if (det && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.match_cnt = cnt_q;
`else
   assign bus.match_cnt = '0;
`endif

   assign bus.det     = det;
   assign bus.armed   = armed_q;
   assign bus.cfg_err = cfgErr_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_param;
   import seq_det_pkg::*;

   typedef struct {
      logic       r;
      logic       we;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ov;
      logic       v;
      logic       b;
      logic       eDet;
      logic       eArm;
      logic       eErr;
   } vec_t;

   logic clk;
   logic rst;
   vec_t vecs[$];
   int   vecCount;
   int   missCount;
   int   expCnt;
   int   cntEnabled;

   seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus ();

   seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic r, input logic we, input logic [7:0] pat,
                                  input logic [3:0] len, input logic ov, input logic v,
                                  input logic b, input logic eDet, input logic eArm,
                                  input logic eErr);
      vec_t t;
      t.r = r; t.we = we; t.pat = pat; t.len = len; t.ov = ov;
      t.v = v; t.b = b; t.eDet = eDet; t.eArm = eArm; t.eErr = eErr;
      return t;
   endfunction

   task automatic addVec(input logic r, input logic we, input logic [7:0] pat,
                         input logic [3:0] len, input logic ov, input logic v,
                         input logic b, input logic eDet, input logic eArm,
                         input logic eErr);
      vecs.push_back(mkVec(r, we, pat, len, ov, v, b, eDet, eArm, eErr));
   endtask

   // One valid bit per character; dets marks where a match is expected.
   task automatic addBits(input string bits, input string dets, input logic arm);
      for (int i = 0; i < bits.len(); i++) begin
         addVec(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, bits[i] == "1",
                dets[i] == "1", arm, 1'b0);
      end
   endtask

   task automatic checkOutput(input vec_t t);
      int wantCnt;
      wantCnt = (cntEnabled != 0) ? expCnt : 0;
      if (bus.det !== t.eDet) begin
         missCount++;
         $display("[TB] FAIL det vec %0d: got %b want %b", vecCount, bus.det, t.eDet);
      end
      if (bus.armed !== t.eArm) begin
         missCount++;
         $display("[TB] FAIL armed vec %0d: got %b want %b", vecCount, bus.armed, t.eArm);
      end
      if (bus.cfg_err !== t.eErr) begin
         missCount++;
         $display("[TB] FAIL cfg_err vec %0d: got %b want %b", vecCount, bus.cfg_err, t.eErr);
      end
      if (bus.match_cnt !== 2'(wantCnt)) begin
         missCount++;
         $display("[TB] FAIL match_cnt vec %0d: got %0d want %0d", vecCount, bus.match_cnt, wantCnt);
      end
   endtask

   // Drive one cycle's inputs mid-period, check before the rising edge, then advance the count model.
   task automatic applyStimulus(input vec_t t);
      @(negedge clk);
      rst             = t.r;
      bus.cfg_we      = t.we;
      bus.cfg_pattern = t.pat;
      bus.cfg_len     = t.len;
      bus.cfg_overlap = t.ov;
      bus.in_valid    = t.v;
      bus.in          = t.b;
      #1;
      checkOutput(t);
      vecCount++;
      if (t.r || t.we)
         expCnt = 0;
      else if (t.eDet && expCnt != 3)
         expCnt++;
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      expCnt    = 0;
`ifdef SEQ_DET_CNT_EN
      cntEnabled = 1;
`else
      cntEnabled = 0;
`endif
      rst             = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in          = 1'b0;
      repeat (2) @(posedge clk);

      addVec(1, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 0);

      // len 5 overlapping: two matches in a 15-bit stream
      addVec(0, 1, 8'b11010, 4'd5, 1, 0, 0, 0, 0, 0);
      addBits("011010010110101", "000001000000010", 1'b1);

      // 1011 with and without overlap
      addVec(0, 1, 8'b1011, 4'd4, 1, 0, 0, 0, 1, 0);
      addBits("1011011", "0001001", 1'b1);
      addVec(0, 1, 8'b1011, 4'd4, 0, 0, 0, 0, 1, 0);
      addBits("1011011", "0001000", 1'b1);

      // 101 spread out by invalid gaps
      addVec(0, 1, 8'b101, 4'd3, 1, 0, 0, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 0, 1, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 0, 1, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 0, 1, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 1, 1, 0);

      // illegal lengths 1 and MAX_LEN+1
      addVec(0, 1, 8'b101, 4'd1, 1, 0, 0, 0, 1, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 0, 0, 1);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 0, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 0, 0, 0);
      addVec(0, 1, 8'b101, 4'd9, 1, 0, 0, 0, 0, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 0, 1);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 0, 0, 0);

      // reset mid-pattern loses the partial match and beats cfg_we
      addVec(0, 1, 8'b11010, 4'd5, 0, 0, 0, 0, 0, 0);
      addBits("1101", "0000", 1'b1);
      addVec(1, 0, 8'd0, 4'd0, 0, 1, 0, 0, 1, 0);
      addVec(1, 1, 8'b11010, 4'd5, 0, 0, 0, 0, 0, 0);
      addVec(0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 0, 0);
      addVec(0, 1, 8'b11010, 4'd5, 0, 0, 0, 0, 0, 0);
      addBits("011010", "000001", 1'b1);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Counter saturation and cfg_we beating a same-cycle valid bit
      applyStimulus(mkVec(0, 1, 8'b11, 4'd2, 1, 0, 0, 0, 1, 0));
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mkVec(0, 0, 8'd0, 4'd0, 0, 1, 1, i > 0, 1, 0));
      end
      applyStimulus(mkVec(0, 1, 8'b11, 4'd2, 1, 1, 1, 0, 1, 0));
      applyStimulus(mkVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 0, 1, 0));
      applyStimulus(mkVec(0, 0, 8'd0, 4'd0, 0, 1, 1, 1, 1, 0));
      applyStimulus(mkVec(0, 0, 8'd0, 4'd0, 0, 0, 1, 0, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
